// File: rtl/img_rom_window_if.sv
// ROM read bus between the picture-window fetcher (master) and the image ROM (slave).
interface img_rom_window_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 24
);
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/img_rom_window.sv
// Places a ROM-stored image at a programmable position in the active video area,
// with optional 2x replication and colour-key transparency; outputs are L = RD_LATENCY+2 late.
module img_rom_window #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 24,
  parameter int                    IMG_W      = 256,
  parameter int                    IMG_H      = 200,
  parameter int                    RD_LATENCY = 2,
  parameter int                    H_WIDTH    = 12,
  parameter int                    KEY_EN     = 0,
  parameter logic [DATA_WIDTH-1:0] KEY_COLOR  = 24'h000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vs_in,
  input  logic                  hs_in,
  input  logic                  de_in,
  input  logic                  en,
  input  logic                  scale,
  input  logic [H_WIDTH-1:0]    win_x,
  input  logic [H_WIDTH-1:0]    win_y,
  input  logic [DATA_WIDTH-1:0] bg_color,
  img_rom_window_if.master      rom,
  output logic                  vs_out,
  output logic                  hs_out,
  output logic                  de_out,
  output logic [DATA_WIDTH-1:0] rgb_out
);

  localparam int L  = RD_LATENCY + 2;
  localparam int CW = H_WIDTH + 2;

  localparam logic [CW-1:0]         IMG_W1    = CW'(IMG_W);
  localparam logic [CW-1:0]         IMG_W2    = CW'(2 * IMG_W);
  localparam logic [CW-1:0]         IMG_H1    = CW'(IMG_H);
  localparam logic [CW-1:0]         IMG_H2    = CW'(2 * IMG_H);
  localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(IMG_W);
  localparam logic [ADDR_WIDTH-1:0] ONE_A     = ADDR_WIDTH'(1);
  localparam logic [H_WIDTH-1:0]    ONE_H     = H_WIDTH'(1);

  logic                  vs_prev_q, vs_prev_d;
  logic                  de_prev_q, de_prev_d;
  logic                  en_lat_q, en_lat_d;
  logic                  scale_lat_q, scale_lat_d;
  logic [H_WIDTH-1:0]    win_x_q, win_x_d;
  logic [H_WIDTH-1:0]    win_y_q, win_y_d;
  logic [H_WIDTH-1:0]    col_q, col_d;
  logic [H_WIDTH-1:0]    row_q, row_d;
  logic [ADDR_WIDTH-1:0] x_off_q, x_off_d;
  logic                  x_phase_q, x_phase_d;
  logic [ADDR_WIDTH-1:0] line_base_q, line_base_d;
  logic                  row_phase_q, row_phase_d;
  logic                  row_hit_q, row_hit_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [L-1:0]          vs_sr_q, vs_sr_d;
  logic [L-1:0]          hs_sr_q, hs_sr_d;
  logic [L-1:0]          de_sr_q, de_sr_d;
  logic [L-2:0]          win_sr_q, win_sr_d;
  logic [DATA_WIDTH-1:0] rgb_q, rgb_d;

  logic                  vs_rise, de_fall, in_win;
  logic                  en_eff, scale_eff, x_phase_eff;
  logic [H_WIDTH-1:0]    win_x_eff, win_y_eff, row_eff;
  logic [ADDR_WIDTH-1:0] x_off_eff, line_base_eff;
  logic [CW-1:0]         col_ext, row_ext, wx_ext, wy_ext, x_lim, y_lim;

  // A pixel coinciding with the vs rising edge already sees the new frame's settings.
  always_comb begin
    vs_rise       = vs_in & ~vs_prev_q;
    de_fall       = de_prev_q & ~de_in;
    en_eff        = vs_rise ? en    : en_lat_q;
    scale_eff     = vs_rise ? scale : scale_lat_q;
    win_x_eff     = vs_rise ? win_x : win_x_q;
    win_y_eff     = vs_rise ? win_y : win_y_q;
    row_eff       = vs_rise ? '0 : row_q;
    x_off_eff     = vs_rise ? '0 : x_off_q;
    x_phase_eff   = vs_rise ? 1'b0 : x_phase_q;
    line_base_eff = vs_rise ? '0 : line_base_q;
    col_ext       = {2'b00, col_q};
    row_ext       = {2'b00, row_eff};
    wx_ext        = {2'b00, win_x_eff};
    wy_ext        = {2'b00, win_y_eff};
    x_lim         = wx_ext + (scale_eff ? IMG_W2 : IMG_W1);
    y_lim         = wy_ext + (scale_eff ? IMG_H2 : IMG_H1);
    in_win        = de_in & en_eff &
                    (col_ext >= wx_ext) & (col_ext < x_lim) &
                    (row_ext >= wy_ext) & (row_ext < y_lim);
  end

  always_comb begin
    vs_prev_d   = vs_in;
    de_prev_d   = de_in;
    en_lat_d    = en_lat_q;
    scale_lat_d = scale_lat_q;
    win_x_d     = win_x_q;
    win_y_d     = win_y_q;
    col_d       = de_in ? col_q + ONE_H : '0;
    row_d       = row_q;
    x_off_d     = x_off_q;
    x_phase_d   = x_phase_q;
    line_base_d = line_base_q;
    row_phase_d = row_phase_q;
    row_hit_d   = row_hit_q;
    rom_addr_d  = rom_addr_q;

    if (vs_rise) begin
      en_lat_d    = en;
      scale_lat_d = scale;
      win_x_d     = win_x;
      win_y_d     = win_y;
      row_d       = '0;
      x_off_d     = '0;
      x_phase_d   = 1'b0;
      line_base_d = '0;
      row_phase_d = 1'b0;
      row_hit_d   = 1'b0;
    end

    if (in_win) begin
      rom_addr_d = line_base_eff + x_off_eff;
      row_hit_d  = 1'b1;
      if (!scale_eff || x_phase_eff)
        x_off_d = x_off_eff + ONE_A;
      if (scale_eff)
        x_phase_d = ~x_phase_eff;
    end

    // Line stride only depends on whether the row was hit, so right clipping never skews the image.
    if (de_fall) begin
      x_off_d   = '0;
      x_phase_d = 1'b0;
      row_hit_d = 1'b0;
      if (!vs_rise) begin
        row_d = row_q + ONE_H;
        if (row_hit_q) begin
          if (!scale_lat_q || row_phase_q)
            line_base_d = line_base_q + LINE_STEP;
          if (scale_lat_q)
            row_phase_d = ~row_phase_q;
        end
      end
    end
  end

  always_comb begin
    vs_sr_d  = {vs_sr_q[L-2:0], vs_in};
    hs_sr_d  = {hs_sr_q[L-2:0], hs_in};
    de_sr_d  = {de_sr_q[L-2:0], de_in};
    win_sr_d = {win_sr_q[L-3:0], in_win};
    // Tap L-2 lines up with rom_data for the same pixel; the register adds the last stage.
    if (!de_sr_q[L-2])
      rgb_d = '0;
    else if (!win_sr_q[L-2])
      rgb_d = bg_color;
    else if ((KEY_EN != 0) && (rom.rom_data == KEY_COLOR))
      rgb_d = bg_color;
    else
      rgb_d = rom.rom_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_prev_q   <= 1'b0;
      de_prev_q   <= 1'b0;
      en_lat_q    <= 1'b0;
      scale_lat_q <= 1'b0;
      win_x_q     <= '0;
      win_y_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      x_off_q     <= '0;
      x_phase_q   <= 1'b0;
      line_base_q <= '0;
      row_phase_q <= 1'b0;
      row_hit_q   <= 1'b0;
      rom_addr_q  <= '0;
      vs_sr_q     <= '0;
      hs_sr_q     <= '0;
      de_sr_q     <= '0;
      win_sr_q    <= '0;
      rgb_q       <= '0;
    end else begin
      vs_prev_q   <= vs_prev_d;
      de_prev_q   <= de_prev_d;
      en_lat_q    <= en_lat_d;
      scale_lat_q <= scale_lat_d;
      win_x_q     <= win_x_d;
      win_y_q     <= win_y_d;
      col_q       <= col_d;
      row_q       <= row_d;
      x_off_q     <= x_off_d;
      x_phase_q   <= x_phase_d;
      line_base_q <= line_base_d;
      row_phase_q <= row_phase_d;
      row_hit_q   <= row_hit_d;
      rom_addr_q  <= rom_addr_d;
      vs_sr_q     <= vs_sr_d;
      hs_sr_q     <= hs_sr_d;
      de_sr_q     <= de_sr_d;
      win_sr_q    <= win_sr_d;
      rgb_q       <= rgb_d;
    end
  end

  assign rom.rom_addr = rom_addr_q;
  assign vs_out       = vs_sr_q[L-1];
  assign hs_out       = hs_sr_q[L-1];
  assign de_out       = de_sr_q[L-1];
  assign rgb_out      = rgb_q;

endmodule

// File: tb/tb_img_rom_window.sv
// Bench for img_rom_window: a plain and a colour-keyed instance driven by the same video stream.
module tb_img_rom_window;
  localparam int AW = 16, DW = 24, IW = 4, IH = 3, RDL = 2, HW = 12, L = RDL + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          vs_in = 0, hs_in = 0, de_in = 0, en = 0, scale = 0;
  logic [HW-1:0] win_x = '0, win_y = '0;
  logic [DW-1:0] bg_color = 24'hAAAAAA;
  logic          vs_o, hs_o, de_o, vs_k, hs_k, de_k;
  logic [DW-1:0] rgb_o, rgb_k;

  img_rom_window_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rom_a ();
  img_rom_window_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rom_b ();

  img_rom_window #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IMG_W(IW), .IMG_H(IH),
                   .RD_LATENCY(RDL), .H_WIDTH(HW), .KEY_EN(0), .KEY_COLOR(24'h000000)) dut (
    .clk(clk), .rst(rst), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in), .en(en),
    .scale(scale), .win_x(win_x), .win_y(win_y), .bg_color(bg_color), .rom(rom_a),
    .vs_out(vs_o), .hs_out(hs_o), .de_out(de_o), .rgb_out(rgb_o));

  img_rom_window #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IMG_W(IW), .IMG_H(IH),
                   .RD_LATENCY(RDL), .H_WIDTH(HW), .KEY_EN(1), .KEY_COLOR(24'h000005)) dut_key (
    .clk(clk), .rst(rst), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in), .en(en),
    .scale(scale), .win_x(win_x), .win_y(win_y), .bg_color(bg_color), .rom(rom_b),
    .vs_out(vs_k), .hs_out(hs_k), .de_out(de_k), .rgb_out(rgb_k));

  // ROM content is its own address, read through RD_LATENCY register stages.
  logic [AW-1:0] ra1 = '0, ra2 = '0, rb1 = '0, rb2 = '0;
  always @(posedge clk) begin
    ra1 <= rom_a.rom_addr; ra2 <= ra1;
    rb1 <= rom_b.rom_addr; rb2 <= rb1;
  end
  assign rom_a.rom_data = DW'(ra2);
  assign rom_b.rom_data = DW'(rb2);

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: frame-relative row/col and image coordinates by division.
  bit            m_vsp, m_dep, m_en, m_sc;
  int            m_wx, m_wy, m_row, m_col;
  logic [AW-1:0] m_addr;
  logic          hv[L], hh[L], hd[L];
  logic [DW-1:0] hr[L], hk[L];

  task automatic model_reset();
    m_vsp = 0; m_dep = 0; m_en = 0; m_sc = 0;
    m_wx = 0; m_wy = 0; m_row = 0; m_col = 0; m_addr = '0;
    for (int i = 0; i < L; i++) begin
      hv[i] = 0; hh[i] = 0; hd[i] = 0; hr[i] = '0; hk[i] = '0;
    end
  endtask

  task automatic model_pixel();
    bit inw; int s, a; logic [DW-1:0] px, pk;
    if (vs_in && !m_vsp) begin
      m_en = en; m_sc = scale; m_wx = int'(win_x); m_wy = int'(win_y); m_row = 0;
    end else if (m_dep && !de_in) m_row++;
    if (de_in) m_col = m_dep ? m_col + 1 : 0;
    s   = m_sc ? 2 : 1;
    inw = de_in && m_en && m_col >= m_wx && m_col < m_wx + IW*s &&
          m_row >= m_wy && m_row < m_wy + IH*s;
    a   = inw ? ((m_row - m_wy) / s) * IW + (m_col - m_wx) / s : 0;
    px  = !de_in ? '0 : (inw ? DW'(a) : bg_color);
    pk  = (inw && a == 5) ? bg_color : px;
    for (int i = L-1; i > 0; i--) begin
      hv[i] = hv[i-1]; hh[i] = hh[i-1]; hd[i] = hd[i-1]; hr[i] = hr[i-1]; hk[i] = hk[i-1];
    end
    hv[0] = vs_in; hh[0] = hs_in; hd[0] = de_in; hr[0] = px; hk[0] = pk;
    if (inw) m_addr = AW'(a);
    m_vsp = vs_in; m_dep = de_in;
  endtask

  logic [DW-1:0] cap[16][16], capk[16][16];
  int  orow = 0, ocol = 0;
  bit  ov_prev = 0, od_prev = 0;

  task automatic step();
    if (rst) model_reset(); else model_pixel();
    @(posedge clk); #1;
    chk("vs_out", 32'(vs_o), 32'(hv[L-1]));
    chk("hs_out", 32'(hs_o), 32'(hh[L-1]));
    chk("de_out", 32'(de_o), 32'(hd[L-1]));
    chk("rgb_out", 32'(rgb_o), 32'(hr[L-1]));
    chk("rom_addr", 32'(rom_a.rom_addr), 32'(m_addr));
    chk("key_de_out", 32'(de_k), 32'(hd[L-1]));
    chk("key_vs_hs", {30'd0, vs_k, hs_k}, {30'd0, hv[L-1], hh[L-1]});
    chk("key_rgb_out", 32'(rgb_k), 32'(hk[L-1]));
    chk("key_rom_addr", 32'(rom_b.rom_addr), 32'(m_addr));
    if (hv[L-1] && !ov_prev) begin
      orow = 0; ocol = 0;
      for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) begin
        cap[r][c] = '0; capk[r][c] = '0;
      end
    end
    if (hd[L-1] && orow < 16 && ocol < 16) begin
      cap[orow][ocol] = rgb_o; capk[orow][ocol] = rgb_k; ocol++;
    end
    if (!hd[L-1] && od_prev) begin orow++; ocol = 0; end
    ov_prev = hv[L-1]; od_prev = hd[L-1];
  endtask

  task automatic do_reset();
    rst = 1'b1; #1;
    chk("rst_now_syncs", {29'd0, vs_o, hs_o, de_o}, 32'd0);
    chk("rst_now_rgb", 32'(rgb_o), 32'd0);
    chk("rst_now_addr", 32'(rom_a.rom_addr), 32'd0);
    chk("rst_now_key_rgb", 32'(rgb_k), 32'd0);
    step(); step(); step();
    rst = 1'b0;
  endtask

  task automatic set_cfg(input bit sc, input int wx, input int wy, input bit e);
    scale = sc; win_x = HW'(wx); win_y = HW'(wy); en = e;
  endtask

  // Nine active lines of ten pixels; optional mid-frame config change or reset.
  task automatic run_frame(input int chg_line, input int rst_line);
    vs_in = 1; step(); step(); vs_in = 0; step();
    for (int ln = 0; ln < 9; ln++) begin
      if (ln == chg_line) begin en = 0; win_x = HW'(5); end
      hs_in = 1; step(); hs_in = 0; step(); step(); step();
      de_in = 1;
      for (int c = 0; c < 10; c++) begin
        if (ln == rst_line && c == 4) do_reset();
        step();
      end
      de_in = 0;
    end
    repeat (6) step();
  endtask

  typedef struct { int set; int row; int col; bit keyed; logic [DW-1:0] exp; } vec_t;
  vec_t vt[$];

  task automatic add(input int s, input int r, input int c, input bit k, input logic [DW-1:0] e);
    vec_t v;
    v.set = s; v.row = r; v.col = c; v.keyed = k; v.exp = e;
    vt.push_back(v);
  endtask

  task automatic check_set(input int sid, input string tag);
    foreach (vt[i]) if (vt[i].set == sid)
      chk($sformatf("%s_r%0d_c%0d", tag, vt[i].row, vt[i].col),
          32'(vt[i].keyed ? capk[vt[i].row][vt[i].col] : cap[vt[i].row][vt[i].col]),
          32'(vt[i].exp));
  endtask

  initial begin
    add(0,1,2,0,24'h0); add(0,1,5,0,24'h3); add(0,2,2,0,24'h4); add(0,2,5,0,24'h7);
    add(0,3,3,0,24'h9); add(0,3,5,0,24'hB); add(0,1,1,0,24'hAAAAAA); add(0,1,6,0,24'hAAAAAA);
    add(0,0,3,0,24'hAAAAAA); add(0,4,3,0,24'hAAAAAA);
    add(1,1,2,0,24'h0); add(1,1,3,0,24'h0); add(1,1,4,0,24'h1); add(1,2,9,0,24'h3);
    add(1,3,2,0,24'h4); add(1,4,8,0,24'h7); add(1,5,2,0,24'h8); add(1,6,9,0,24'hB);
    add(1,7,4,0,24'hAAAAAA); add(1,1,1,0,24'hAAAAAA);
    add(2,1,8,0,24'h0); add(2,1,9,0,24'h1); add(2,2,8,0,24'h4); add(2,2,9,0,24'h5);
    add(2,3,8,0,24'h8); add(2,3,9,0,24'h9); add(2,1,7,0,24'hAAAAAA); add(2,4,8,0,24'hAAAAAA);
    add(3,1,2,0,24'hAAAAAA); add(3,2,5,0,24'hAAAAAA); add(3,3,7,0,24'hAAAAAA); add(3,0,0,0,24'hAAAAAA);
    add(4,2,3,1,24'hAAAAAA); add(4,2,2,1,24'h4); add(4,2,4,1,24'h6);

    model_reset();
    repeat (3) step();
    rst = 1'b0;
    repeat (3) step();

    set_cfg(0, 2, 1, 1); run_frame(-1, -1); check_set(0, "t1"); check_set(4, "key");
    set_cfg(1, 2, 1, 1); run_frame(-1, -1); check_set(1, "scale2");
    set_cfg(0, 8, 1, 1); run_frame(-1, -1); check_set(2, "rclip");
    set_cfg(0, 2, 1, 1); run_frame(1, -1);  check_set(0, "midchg_cur");
    run_frame(-1, -1);                      check_set(3, "midchg_next");
    set_cfg(0, 2, 1, 1); run_frame(-1, 2);  run_frame(-1, -1); check_set(0, "after_rst");

    repeat (8) begin
      set_cfg(1'($urandom_range(0, 1)), int'($urandom_range(0, 11)),
              int'($urandom_range(0, 8)), $urandom_range(0, 3) != 0);
      run_frame(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 8)) : -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
